phase_accumulator: RTL and testbench
====================================

// Module: phase_accumulator
// PURPOSE
//  Phase generator (NCO front end) feeding cos_clocked: emits one signed pdQp phase per cycle,
//  wrapped to [-pi_p, +pi_p], advancing by a programmable step. Supports finite bursts or
//  continuous run, phase-continuous retune, abort. Downstream cosine adds 1 cycle; consumer
//  delays o_valid by 1 to align.
// PARAMETERS
//  pd   4   integer bits of phase (incl. sign/overflow), matches cosine input
//  p    9   fractional bits of phase
//  NW   16  width of burst-length counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  i_start    in   1      pulse: load i_phase0/i_step/i_num, begin run
//  i_stop     in   1      pulse: abort run
//  i_phase0   in   pd+p   signed pdQp start phase, caller keeps within [-pi_p, pi_p]
//  i_step     in   pd+p   signed pdQp increment, caller keeps |step| <= pi_p
//  i_step_wr  in   1      pulse: write i_step to shadow reg (retune while running)
//  i_num      in   NW     samples per burst; 0 = continuous until i_stop
//  o_phase    out  pd+p   signed pdQp phase, registered
//  o_valid    out  1      o_phase is a valid sample this cycle
//  o_wrap     out  1      this sample was wrapped by +/-2pi_p
//  o_done     out  1      1-cycle pulse coincident with last burst sample
//  o_busy     out  1      high in RUN
// BEHAVIOUR
//  - Constants (pd=4,p=9 codes): pi_p=1608, pi2_p=3216, pi_half_p=804; derived by truncating
//    4Q22 constants to pdQp, identical to cosine's truncation.
//  - Reset: all outputs 0, state IDLE, phase/step/shadow/counter 0. rst mid-run aborts, no o_done.
//  - FSM IDLE->RUN on i_start (and not i_stop). RUN->IDLE on i_stop, or after last sample.
//    i_start in RUN: restart (reload all, counter cleared), no o_done for aborted burst.
//    i_start & i_stop same cycle: stop wins, stay/return IDLE.
//  - Latency: cycle after i_start: o_valid=1, o_phase=i_phase0, o_wrap=0.
//    Each following RUN cycle: s = phase + step computed in pd+p+1 bits;
//    s > pi_p -> s - pi2_p, o_wrap=1; s < -pi_p -> s + pi2_p, o_wrap=1; else s, o_wrap=0.
//    Exactly +/-pi_p is NOT wrapped. Result always fits pd+p signed.
//  - Burst: counter counts emitted samples; with i_num=N>0 exactly N samples, o_done=1 with
//    the Nth, then IDLE (o_valid=0 next cycle). i_num=1: single sample + o_done same cycle.
//  - i_stop in RUN: o_valid drops next cycle, o_done never asserted; o_phase holds last value.
//  - Retune: i_step_wr loads shadow; shadow copied into active step at next sample boundary,
//    so the sample two cycles after i_step_wr uses new step (phase continuous, no reset).
//    i_step_wr in IDLE updates shadow only; i_start overwrites both with i_step.
//  - o_busy = (state==RUN); o_phase/o_wrap hold in IDLE, o_valid=0 in IDLE.
// STRUCTURE
//  - Shared header (fixed_point_consts.vh): 4Q22 pi, 2pi, pi/2 and pdQp truncation macro;
//    also used by cos_clocked so wrap limits stay bit-identical.
//  - One sub-module natural: phase_wrap (combinational add + +/-2pi_p fold, flag out).
//  - Top: FSM, phase reg, active/shadow step regs, NW-bit sample counter.
// TESTING
//  1 step=804, phase0=0, num=6 -> o_phase 0,804,1608,-804,0,804; o_wrap only on 4th; o_done on 6th.
//  2 step=-804, phase0=0, num=4 -> 0,-804,-1608,804; wrap on 4th; -1608 unwrapped.
//  3 num=0, step=1, phase0=1607 -> 1607,1608,-1607,...; runs until i_stop; o_valid low cycle after stop; no o_done.
//  4 running step=100 from 0, i_step_wr step=200 at sample 3 -> 0,100,200,300,500,700.
//  5 rst asserted mid-burst -> next cycle all outputs 0, IDLE; i_start+i_stop together -> stays IDLE.
//  6 i_num=1 -> single valid sample with o_done same cycle; chained to cos_clocked, phase0=0 gives cos ~ 512 (1.0 3Q9) one cycle later.

Source files
------------

// File: rtl/phase_accumulator_pkg.sv
// Shared fixed-point constants and types for the phase accumulator.
// The 4Q22 constants are the same values cos_clocked truncates, so the wrap limits match bit for bit.
package phase_accumulator_pkg;

  localparam int PD    = 4;
  localparam int P     = 9;
  localparam int NUM_W = 16;

  localparam int FRAC_REF = 22;
  localparam longint PI_4Q22      = 64'd13176795;
  localparam longint PI2_4Q22     = 64'd26353589;
  localparam longint PI_HALF_4Q22 = 64'd6588397;

  // Truncate a 4Q22 constant to frac fractional bits.
  function automatic int to_pdqp(input longint c, input int frac);
    return int'(c >>> (FRAC_REF - frac));
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/phase_accumulator_phase_wrap.sv
// Combinational phase advance: phase + step in one extra bit, folded by +/-2pi back into range.
module phase_wrap #(
  parameter int W       = 13,
  parameter int PI_LIM  = 1608,
  parameter int PI2_LIM = 3216
) (
  input  logic signed [W-1:0] i_phase,
  input  logic signed [W-1:0] i_step,
  output logic signed [W-1:0] o_sum,
  output logic                o_wrap
);

  logic signed [W:0] sum_ext;
  logic signed [W:0] folded;
  logic signed [W:0] pi_ext;
  logic signed [W:0] pi2_ext;

  assign pi_ext  = (W+1)'(PI_LIM);
  assign pi2_ext = (W+1)'(PI2_LIM);

  // Exactly +/-pi stays put; only strictly outside the range folds.
  always_comb begin
    sum_ext = {i_phase[W-1], i_phase} + {i_step[W-1], i_step};
    folded  = sum_ext;
    o_wrap  = 1'b0;
    if (sum_ext > pi_ext) begin
      folded = sum_ext - pi2_ext;
      o_wrap = 1'b1;
    end else if (sum_ext < -pi_ext) begin
      folded = sum_ext + pi2_ext;
      o_wrap = 1'b1;
    end
    o_sum = folded[W-1:0];
  end

endmodule

// File: rtl/phase_accumulator.sv
// NCO phase front end: one wrapped pdQp phase per cycle, burst or continuous,
// with phase-continuous retune through a shadow step register.
module phase_accumulator
  import phase_accumulator_pkg::*;
#(
  parameter int pd = PD,
  parameter int p  = P,
  parameter int NW = NUM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [pd+p-1:0]    i_phase0,
  input  logic [pd+p-1:0]    i_step,
  input  logic               i_step_wr,
  input  logic [NW-1:0]      i_num,
  output logic [pd+p-1:0]    o_phase,
  output logic               o_valid,
  output logic               o_wrap,
  output logic               o_done,
  output logic               o_busy
);

  localparam int W       = pd + p;
  localparam int PI_LIM  = to_pdqp(PI_4Q22, p);
  localparam int PI2_LIM = to_pdqp(PI2_4Q22, p);

  state_e        state_q, state_d;
  logic [W-1:0]  phase_q, phase_d;
  logic [W-1:0]  step_q, step_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [NW-1:0] count_q, count_d;
  logic [NW-1:0] num_q, num_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;

  logic [W-1:0]  next_phase;
  logic          next_wrap;
  logic [NW-1:0] count_inc;
  logic          start_ok;

  assign count_inc = count_q + NW'(1);
  assign start_ok  = i_start && !i_stop;

  // The shadow step becomes active at this sample boundary, so the adder uses it directly.
  phase_wrap #(
    .W       (W),
    .PI_LIM  (PI_LIM),
    .PI2_LIM (PI2_LIM)
  ) u_phase_wrap (
    .i_phase (phase_q),
    .i_step  (shadow_q),
    .o_sum   (next_phase),
    .o_wrap  (next_wrap)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    step_d   = step_q;
    shadow_d = i_step_wr ? i_step : shadow_q;
    count_d  = count_q;
    num_d    = num_q;
    valid_d  = 1'b0;
    wrap_d   = wrap_q;
    done_d   = 1'b0;

    if (start_ok) begin
      state_d  = ST_RUN;
      phase_d  = i_phase0;
      step_d   = i_step;
      shadow_d = i_step;
      num_d    = i_num;
      count_d  = NW'(1);
      valid_d  = 1'b1;
      wrap_d   = 1'b0;
      done_d   = (i_num == NW'(1));
    end else if (state_q == ST_RUN) begin
      // done_q marks the sample just emitted as the last of the burst.
      if (i_stop || done_q) begin
        state_d = ST_IDLE;
      end else begin
        step_d  = shadow_q;
        phase_d = next_phase;
        wrap_d  = next_wrap;
        count_d = count_inc;
        valid_d = 1'b1;
        done_d  = (num_q != '0) && (count_inc == num_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      step_q   <= '0;
      shadow_q <= '0;
      count_q  <= '0;
      num_q    <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  assign o_phase = phase_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;
  assign o_done  = done_q;
  assign o_busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_phase_accumulator.sv
// Scoreboard bench for phase_accumulator: directed bursts push expected samples,
// a negedge monitor pops and compares every valid output.
module tb_phase_accumulator;
  import phase_accumulator_pkg::*;

  localparam int W  = PD + P;
  localparam int EW = W + 2;

  logic             clk;
  logic             rst;
  logic             i_start;
  logic             i_stop;
  logic [W-1:0]     i_phase0;
  logic [W-1:0]     i_step;
  logic             i_step_wr;
  logic [NUM_W-1:0] i_num;
  logic [W-1:0]     o_phase;
  logic             o_valid;
  logic             o_wrap;
  logic             o_done;
  logic             o_busy;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  phase_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_phase0  (i_phase0),
    .i_step    (i_step),
    .i_step_wr (i_step_wr),
    .i_num     (i_num),
    .o_phase   (o_phase),
    .o_valid   (o_valid),
    .o_wrap    (o_wrap),
    .o_done    (o_done),
    .o_busy    (o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    if (o_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample got phase=%0d wrap=%0b done=%0b, queue empty",
                 $signed(o_phase), o_wrap, o_done);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_wrap, o_done, o_phase} !== mon_exp) begin
          errors++;
          $display("FAIL sample got phase=%0d wrap=%0b done=%0b required phase=%0d wrap=%0b done=%0b",
                   $signed(o_phase), o_wrap, o_done,
                   $signed(mon_exp[W-1:0]), mon_exp[W+1], mon_exp[W]);
        end
      end
    end
  end

  task automatic push_exp(input int ph, input bit wrap, input bit done);
    exp_q.push_back({wrap, done, W'(ph)});
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // driver: one-cycle start pulse, returns just after the loading edge
  task automatic start(input int ph0, input int st, input int n);
    i_phase0 = W'(ph0);
    i_step   = W'(st);
    i_num    = NUM_W'(n);
    i_start  = 1'b1;
    @(posedge clk);
    #1;
    i_start  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got busy=%0b required 0", name, o_busy);
    end
  endtask

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_stop    = 1'b0;
    i_phase0  = '0;
    i_step    = '0;
    i_step_wr = 1'b0;
    i_num     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_phase", $signed(o_phase), 0);
    check("rst_busy",  int'(o_busy), 0);
    check("rst_wrap",  int'(o_wrap), 0);
    check("rst_done",  int'(o_done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // burst, positive step, +pi not wrapped
    push_exp(0, 0, 0); push_exp(804, 0, 0); push_exp(1608, 0, 0);
    push_exp(-804, 1, 0); push_exp(0, 0, 0); push_exp(804, 0, 1);
    start(0, 804, 6);
    wait_idle("t1_idle");
    check("t1_valid_after", int'(o_valid), 0);
    check("t1_phase_hold", $signed(o_phase), 804);

    // burst, negative step, -pi not wrapped
    push_exp(0, 0, 0); push_exp(-804, 0, 0); push_exp(-1608, 0, 0); push_exp(804, 1, 1);
    start(0, -804, 4);
    wait_idle("t2_idle");
    check("t2_valid_after", int'(o_valid), 0);

    // continuous run stopped by i_stop after five samples
    push_exp(1607, 0, 0); push_exp(1608, 0, 0); push_exp(-1607, 1, 0);
    push_exp(-1606, 0, 0); push_exp(-1605, 0, 0);
    start(1607, 1, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    i_stop = 1'b1;
    @(posedge clk);
    #1;
    i_stop = 1'b0;
    check("t3_valid_after_stop", int'(o_valid), 0);
    check("t3_done_after_stop",  int'(o_done), 0);
    check("t3_busy_after_stop",  int'(o_busy), 0);
    check("t3_phase_hold", $signed(o_phase), -1605);

    // retune mid-burst
    push_exp(0, 0, 0); push_exp(100, 0, 0); push_exp(200, 0, 0);
    push_exp(300, 0, 0); push_exp(500, 0, 0); push_exp(700, 0, 1);
    start(0, 100, 6);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    i_step    = W'(200);
    i_step_wr = 1'b1;
    @(posedge clk);
    #1;
    i_step_wr = 1'b0;
    wait_idle("t4_idle");

    // reset mid-burst, then start+stop together
    push_exp(0, 0, 0); push_exp(50, 0, 0); push_exp(100, 0, 0);
    start(0, 50, 10);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_rst_valid", int'(o_valid), 0);
    check("t5_rst_phase", $signed(o_phase), 0);
    check("t5_rst_busy",  int'(o_busy), 0);
    check("t5_rst_done",  int'(o_done), 0);
    i_phase0 = W'(77);
    i_start  = 1'b1;
    i_stop   = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    check("t5_startstop_valid", int'(o_valid), 0);
    check("t5_startstop_busy",  int'(o_busy), 0);
    check("t5_startstop_phase", $signed(o_phase), 0);

    // single-sample burst
    push_exp(0, 0, 1);
    start(0, 5, 1);
    check("t6_busy", int'(o_busy), 1);
    check("t6_done", int'(o_done), 1);
    @(posedge clk);
    #1;
    check("t6_valid_after", int'(o_valid), 0);
    check("t6_busy_after",  int'(o_busy), 0);

    // restart while running: first burst abandoned without o_done
    push_exp(0, 0, 0); push_exp(500, 0, 0); push_exp(520, 0, 0); push_exp(540, 0, 1);
    start(0, 10, 0);
    start(500, 20, 3);
    wait_idle("t7_idle");
    check("t7_valid_after", int'(o_valid), 0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
